// File: rtl/rd_pattern_gen.sv
// Read-side pattern checker: sweeps the address space in fixed bursts, issues read
// requests and checks returned beats against an address-derived incrementing pattern.
module rd_pattern_gen #(
    parameter int unsigned     ADDR_WIDTH = 26,
    parameter int unsigned     DATA_WIDTH = 32,
    parameter logic [7:0]      BURST_LEN  = 8'd8,
    parameter longint unsigned ADDR_LIMIT = 64'd1 << ADDR_WIDTH,
    parameter int unsigned     TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic                  enable,
    output logic                  rd_trig,
    output logic [7:0]            rd_len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_ready,
    input  logic                  rd_done,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_data_en,
    output logic                  busy,
    output logic                  err_flag,
    output logic [15:0]           err_cnt,
    output logic [15:0]           burst_cnt,
    output logic                  timeout
);

    localparam int unsigned     WD_W = $clog2(TIMEOUT + 1);
    localparam longint unsigned STEP = 64'(BURST_LEN) * 64'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              beat_q, beat_d;
    logic                    done_seen_q, done_seen_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic                    trig_q, trig_d;
    logic                    busy_q, busy_d;
    logic                    err_flag_q, err_flag_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [15:0]             burst_cnt_q, burst_cnt_d;
    logic                    timeout_q, timeout_d;

    logic [1:0]              err_inc;
    logic [16:0]             err_sum;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic [63:0]             addr_sum;
    logic [ADDR_WIDTH-1:0]   addr_nxt;

    // Expected beat value and next sweep address (wraps when the following burst would overrun)
    always_comb begin
        exp_data = DATA_WIDTH'(64'(addr_q >> 1) + 64'(beat_q) + 64'd1);
        addr_sum = 64'(addr_q) + STEP;
        addr_nxt = (addr_sum + STEP > ADDR_LIMIT) ? '0 : ADDR_WIDTH'(addr_sum);
    end

    // Next-state and checker logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        done_seen_d = done_seen_q;
        wdog_d      = wdog_q;
        trig_d      = 1'b0;
        burst_cnt_d = burst_cnt_q;
        timeout_d   = timeout_q;
        err_inc     = 2'd0;

        if (rd_data_en) begin
            if (state_q == S_WAIT && beat_q < BURST_LEN) begin
                beat_d = beat_q + 8'd1;
                if (rd_data != exp_data) err_inc = err_inc + 2'd1;
            end else begin
                err_inc = err_inc + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (init_end && enable) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (rd_ready) begin
                    trig_d      = 1'b1;
                    state_d     = S_WAIT;
                    beat_d      = 8'd0;
                    done_seen_d = 1'b0;
                    wdog_d      = '0;
                end
            end
            S_WAIT: begin
                if (rd_done) done_seen_d = 1'b1;
                wdog_d = wdog_q + WD_W'(1);
                // A same-cycle last beat and rd_done both count via beat_d / rd_done
                if ((done_seen_q || rd_done) && beat_d == BURST_LEN) begin
                    state_d = S_NEXT;
                end else if (32'(wdog_q) + 32'd1 == TIMEOUT) begin
                    timeout_d = 1'b1;
                    err_inc   = err_inc + 2'd1;
                    state_d   = S_IDLE;
                end
            end
            S_NEXT: begin
                burst_cnt_d = burst_cnt_q + 16'd1;
                addr_d      = addr_nxt;
                state_d     = enable ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        err_sum    = 17'(err_cnt_q) + 17'(err_inc);
        err_cnt_d  = (err_sum > 17'h0FFFF) ? 16'hFFFF : err_sum[15:0];
        err_flag_d = err_flag_q | (err_inc != 2'd0);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beat_q      <= 8'd0;
            done_seen_q <= 1'b0;
            wdog_q      <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= 16'd0;
            burst_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            done_seen_q <= done_seen_d;
            wdog_q      <= wdog_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign rd_trig   = trig_q;
    assign rd_len    = BURST_LEN;
    assign rd_addr   = addr_q;
    assign busy      = busy_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;
    assign burst_cnt = burst_cnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rd_pattern_gen.sv
// Directed bench for rd_pattern_gen: a small read-slave model returns bursts with
// optional corruption, overrun, coincident done, dropped enable, timeout and reset.
module tb_rd_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        init_end;
    logic        enable;
    logic        rd_trig;
    logic [7:0]  rd_len;
    logic [25:0] rd_addr;
    logic        rd_ready;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        rd_data_en;
    logic        busy;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [15:0] burst_cnt;
    logic        timeout;

    int n_vec;
    int n_err;

    rd_pattern_gen #(
        .ADDR_WIDTH(26),
        .DATA_WIDTH(32),
        .BURST_LEN (8'd8),
        .ADDR_LIMIT(64'd64),
        .TIMEOUT   (1024)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_end  (init_end),
        .enable    (enable),
        .rd_trig   (rd_trig),
        .rd_len    (rd_len),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .rd_data_en(rd_data_en),
        .busy      (busy),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt),
        .burst_cnt (burst_cnt),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_trig) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("trig_seen", 32'(ok), 32'd1);
    endtask

    // One burst from the slave model; bad_beat < 0 means no corruption
    task automatic run_burst(input logic [25:0] exp_addr, input int bad_beat, input logic coincide,
                             input logic extra, input logic drop_en, input logic [15:0] exp_bc);
        logic        ok;
        logic [25:0] a;
        wait_trig(ok);
        if (!ok) return;
        a = rd_addr;
        chk("rd_addr", 32'(a), 32'(exp_addr));
        chk("rd_len", 32'(rd_len), 32'd8);
        if (drop_en) enable = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_data_en = 1'b1;
            rd_data    = 32'(a >> 1) + 32'(k) + 32'd1;
            if (k == bad_beat) begin
                rd_data = 32'd0;
                chk("err_flag_pre", 32'(err_flag), 32'd0);
            end
            if (coincide && k == 7) rd_done = 1'b1;
            step();
            if (k == bad_beat) chk("err_flag_next", 32'(err_flag), 32'd1);
        end
        rd_data_en = 1'b0;
        rd_done    = 1'b0;
        if (extra) begin
            rd_data_en = 1'b1;
            rd_data    = 32'hDEAD;
            step();
            rd_data_en = 1'b0;
        end
        if (!coincide) begin
            rd_done = 1'b1;
            step();
            rd_done = 1'b0;
        end
        step();
        chk("burst_cnt", 32'(burst_cnt), 32'(exp_bc));
    endtask

    initial begin
        logic ok;
        int   trigs;
        int   cyc;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; init_end = 1'b0; enable = 1'b0; rd_ready = 1'b1;
        rd_done = 1'b0; rd_data = 32'd0; rd_data_en = 1'b0;
        step(); step();
        chk("rst_rd_len", 32'(rd_len), 32'd8);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig", 32'(rd_trig), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Gating: enable without init_end must never trigger
        enable = 1'b1;
        trigs  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd_trig) trigs++;
        end
        chk("gate_trigs", 32'(trigs), 32'd0);
        chk("gate_busy", 32'(busy), 32'd0);

        // Sweep: 0,16,32 clean; 48 with coincident done; wrap to 0
        init_end = 1'b1;
        run_burst(26'd0,  -1, 1'b0, 1'b0, 1'b0, 16'd1);
        run_burst(26'd16, -1, 1'b0, 1'b0, 1'b0, 16'd2);
        run_burst(26'd32, -1, 1'b0, 1'b0, 1'b0, 16'd3);
        chk("normal_err_cnt", 32'(err_cnt), 32'd0);
        run_burst(26'd48, -1, 1'b1, 1'b0, 1'b0, 16'd4);
        chk("coinc_err_cnt", 32'(err_cnt), 32'd0);
        run_burst(26'd0,  -1, 1'b0, 1'b0, 1'b0, 16'd5);
        // Beat 3 at A=16 expects 8+3+1=12; 0 is sent instead
        run_burst(26'd16,  3, 1'b0, 1'b0, 1'b0, 16'd6);
        chk("mismatch_err_cnt", 32'(err_cnt), 32'd1);
        run_burst(26'd32, -1, 1'b0, 1'b1, 1'b0, 16'd7);
        chk("overrun_err_cnt", 32'(err_cnt), 32'd2);
        run_burst(26'd48, -1, 1'b0, 1'b0, 1'b1, 16'd8);
        chk("drop_en_busy", 32'(busy), 32'd0);
        trigs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_trig) trigs++;
        end
        chk("drop_en_trigs", 32'(trigs), 32'd0);
        chk("wrap_addr_after", 32'(rd_addr), 32'd0);

        // Stray beat while idle
        rd_data_en = 1'b1; rd_data = 32'd1;
        step();
        rd_data_en = 1'b0;
        chk("stray_err_cnt", 32'(err_cnt), 32'd3);

        // Timeout: rd_done never arrives
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_err_flag", 32'(err_flag), 32'd0);
        chk("rst2_err_cnt", 32'(err_cnt), 32'd0);
        enable = 1'b1;
        wait_trig(ok);
        enable = 1'b0;
        chk("tmo_pre", 32'(timeout), 32'd0);
        cyc = 0;
        while (busy && cyc < 1200) begin
            step();
            cyc++;
        end
        chk("tmo_cycles", 32'(cyc), 32'd1024);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_err_flag", 32'(err_flag), 32'd1);
        chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_addr", 32'(rd_addr), 32'd0);
        chk("tmo_burst_cnt", 32'(burst_cnt), 32'd0);

        // Reset mid-burst abandons it; a beat after release while idle is an error
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        enable = 1'b1;
        run_burst(26'd0, -1, 1'b0, 1'b0, 1'b0, 16'd1);
        wait_trig(ok);
        chk("mid_addr", 32'(rd_addr), 32'd16);
        for (int k = 0; k < 3; k++) begin
            rd_data_en = 1'b1;
            rd_data    = 32'd8 + 32'(k) + 32'd1;
            step();
        end
        rd_data_en = 1'b0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        rd_data_en = 1'b1; rd_data = 32'd12;
        step();
        rd_data_en = 1'b0;
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd1);
        chk("post_rst_err_flag", 32'(err_flag), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rd_pattern_gen.md
RD_PATTERN_GEN -- requirements
Module: rd_pattern_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26, meaning width of the read address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of the read data.
REQ-003 SHALL have parameter BURST_LEN, default 8'd8, meaning beats per burst (1..255).
REQ-004 SHALL have parameter ADDR_LIMIT, default 2**ADDR_WIDTH, meaning the exclusive upper bound of swept addresses.
REQ-005 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles spent in WAIT.
REQ-006 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- init_end, in, 1: memory initialisation done.
- enable, in, 1: run sweep while high.
- rd_trig, out, 1: one-cycle read request.
- rd_len, out, 8: equals BURST_LEN.
- rd_addr, out, ADDR_WIDTH: burst start address.
- rd_ready, in, 1: downstream master idle.
- rd_done, in, 1: burst complete pulse.
- rd_data, in, DATA_WIDTH: returned read data.
- rd_data_en, in, 1: rd_data valid.
- busy, out, 1: state is not IDLE.
- err_flag, out, 1: sticky mismatch or protocol error.
- err_cnt, out, 16: saturating error count.
- burst_cnt, out, 16: bursts completed, wrapping.
- timeout, out, 1: sticky watchdog flag.

Function
REQ-007 SHALL implement the states IDLE, ISSUE, WAIT and NEXT.
REQ-008 IDLE SHALL go to ISSUE when init_end and enable are both high; otherwise it SHALL stay in IDLE.
REQ-009 ISSUE SHALL assert rd_trig for exactly one cycle, in the first ISSUE cycle with rd_ready=1, and SHALL then go to WAIT; rd_addr and rd_len SHALL be held stable from ISSUE until NEXT.
REQ-010 WAIT SHALL go to NEXT only when rd_done has been seen AND beat_cnt equals BURST_LEN; rd_done and the last rd_data_en arriving in the same cycle SHALL satisfy both conditions.
REQ-011 NEXT SHALL increment burst_cnt, add 2*BURST_LEN to rd_addr, and go to ISSUE if enable=1, else to IDLE.
REQ-012 Address wrap: if the new address + 2*BURST_LEN > ADDR_LIMIT, rd_addr SHALL become 0.
REQ-013 Expected data for beat k (k = 0..BURST_LEN-1) of a burst at address A SHALL be (A>>1)+k+1, zero-extended and taken modulo 2^DATA_WIDTH.
REQ-014 Each rd_data_en in WAIT with beat_cnt < BURST_LEN SHALL compare rd_data against the expected value and increment beat_cnt; a mismatch SHALL count as one error.
REQ-015 rd_data_en outside WAIT, or with beat_cnt == BURST_LEN, SHALL count as one error, and the data SHALL be ignored.
REQ-016 On each error, err_flag SHALL be set on the next clock; err_cnt SHALL increment and saturate at 16'hFFFF.
REQ-017 The watchdog SHALL clear on entry to WAIT and count each WAIT cycle; on reaching TIMEOUT it SHALL set timeout and err_flag, count one error, and force IDLE without updating the address.
REQ-018 Deasserting enable mid-burst SHALL NOT abort the burst; the generator SHALL return to IDLE at NEXT.
REQ-019 rd_data_en SHALL be sampled and checked with zero-cycle input latency; all outputs SHALL be registered.
REQ-020 err_flag and timeout SHALL clear only on reset.

Reset
REQ-021 While rst_n=0 at a clock edge, the generator SHALL enter IDLE, and the following SHALL be 0: rd_trig, rd_addr, busy, err_flag, err_cnt, burst_cnt, timeout, beat_cnt, watchdog.
REQ-022 rd_len SHALL equal BURST_LEN at all times, including during reset.
REQ-023 Reset asserted mid-burst SHALL abandon the burst, and rd_data_en arriving after reset release while IDLE SHALL count as an error per REQ-015.

Verification
REQ-024 Normal: init_end=1, enable=1, model returns 8 beats (A>>1)+k+1 then rd_done -> rd_addr sequence 0, 16, 32; burst_cnt=3 after 3 bursts; err_cnt=0.
REQ-025 Mismatch: corrupt beat 3 of burst at A=16 (send 0 instead of 12) -> err_flag=1 one cycle later, err_cnt=1, sweep continues to A=32.
REQ-026 Timeout: model never asserts rd_done -> after 1024 WAIT cycles timeout=1, err_cnt=1, busy=0.
REQ-027 Wrap: ADDR_LIMIT=64, BURST_LEN=8 -> rd_addr 0, 16, 32, 48, 0.
REQ-028 Coincidence and overrun: last beat and rd_done in the same cycle -> NEXT next cycle with no error; a 9th beat -> err_cnt +1.
REQ-029 Gating: init_end=0 with enable=1 -> rd_trig never asserted; enable dropped mid-burst -> burst finishes, then IDLE with burst_cnt incremented.
